// File: rtl/relu_pool_2x2_if.sv
// Stream interface for relu_pool_2x2: 48-bit three-channel pixels in, 24-bit pooled pixels out.
interface relu_pool_2x2_if;
  logic        in_valid;
  logic        in_sof;
  logic [47:0] in_pix;
  logic        out_valid;
  logic [23:0] out_pix;
  logic        frame_done;

  modport master (output in_valid, in_sof, in_pix, input out_valid, out_pix, frame_done);
  modport slave  (input in_valid, in_sof, in_pix, output out_valid, out_pix, frame_done);
endinterface

// File: rtl/relu_pool_2x2.sv
// ReLU, requantise to unsigned 8 bits with saturation, then 2x2/stride-2 max pool on a raster stream.
// Define RELU_POOL_ROUND_EN to round half-up before the shift instead of truncating.

module relu_pool_2x2_lane #(
  parameter int SHIFT = 7
) (
  input  logic [15:0] din,
  input  logic [7:0]  hold,
  input  logic [7:0]  lb,
  output logic [7:0]  q8,
  output logic [7:0]  hmax,
  output logic [7:0]  vmax
);
  logic [15:0] v;
  logic [16:0] q;

  assign v = din[15] ? 16'd0 : din;
`ifdef RELU_POOL_ROUND_EN
  assign q = ({1'b0, v} + (17'd1 << (SHIFT - 1))) >> SHIFT;
`else
  assign q = {1'b0, v} >> SHIFT;
`endif
  assign q8   = (q > 17'd255) ? 8'hFF : q[7:0];
  assign hmax = (hold > q8) ? hold : q8;
  assign vmax = (lb > hmax) ? lb : hmax;
endmodule

module relu_pool_2x2 #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int SHIFT = 7
) (
  input  logic           clk,
  input  logic           rst,
  relu_pool_2x2_if.slave bus
);
  localparam int NUM_LANES = 3;
  localparam int VEC_W     = 8;
  localparam int CW        = $clog2(IMG_W);
  localparam int RW        = $clog2(IMG_H);
  localparam int LB_AW     = (IMG_W > 2) ? $clog2(IMG_W / 2) : 1;

  logic [CW-1:0]    col, eff_col;
  logic [RW-1:0]    row, eff_row;
  logic [LB_AW-1:0] lb_idx;
  logic             fire, last_win;

  logic [NUM_LANES-1:0][15:0]      din;
  logic [NUM_LANES-1:0][VEC_W-1:0] hold, q8, hmax, lb_rd, vmax;
  // One pooled-row entry per horizontal pair; contents are never reset.
  logic [NUM_LANES-1:0][VEC_W-1:0] line_buf [2**LB_AW];

  // SOF forces this pixel to (0,0) so any half-built window is simply overwritten.
  assign din      = bus.in_pix;
  assign eff_col  = bus.in_sof ? '0 : col;
  assign eff_row  = bus.in_sof ? '0 : row;
  assign lb_idx   = LB_AW'(eff_col >> 1);
  assign lb_rd    = line_buf[lb_idx];
  assign fire     = bus.in_valid & eff_row[0] & eff_col[0];
  assign last_win = (eff_col == CW'(IMG_W - 1)) & (eff_row == RW'(IMG_H - 1));

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    relu_pool_2x2_lane #(.SHIFT(SHIFT)) u_lane (
      .din  (din[g]),
      .hold (hold[g]),
      .lb   (lb_rd[g]),
      .q8   (q8[g]),
      .hmax (hmax[g]),
      .vmax (vmax[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col  <= '0;
      row  <= '0;
      hold <= '0;
    end else if (bus.in_valid) begin
      if (eff_col == CW'(IMG_W - 1)) begin
        col <= '0;
        row <= (eff_row == RW'(IMG_H - 1)) ? '0 : eff_row + 1'b1;
      end else begin
        col <= eff_col + 1'b1;
        row <= eff_row;
      end
      if (!eff_col[0]) hold <= q8;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && bus.in_valid && !eff_row[0] && eff_col[0]) line_buf[lb_idx] <= hmax;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid  <= 1'b0;
      bus.out_pix    <= '0;
      bus.frame_done <= 1'b0;
    end else begin
      bus.out_valid  <= fire;
      bus.frame_done <= fire & last_win;
      if (fire) bus.out_pix <= vmax;
    end
  end
endmodule

// File: tb/tb_relu_pool_2x2.sv
// Bench for relu_pool_2x2: a 4x2 and a 4x4 instance checked every cycle against a frame-array model,
// plus literal expectations for the directed cases.
module tb_relu_pool_2x2;
  localparam int SH = 7;
  typedef struct { logic [23:0] pix; logic done; int cyc; } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  relu_pool_2x2_if ifa();
  relu_pool_2x2_if ifb();

  relu_pool_2x2 #(.IMG_W(4), .IMG_H(2), .SHIFT(SH)) ua (.clk(clk), .rst(rst), .bus(ifa.slave));
  relu_pool_2x2 #(.IMG_W(4), .IMG_H(4), .SHIFT(SH)) ub (.clk(clk), .rst(rst), .bus(ifb.slave));

  logic        iv[2], isof[2], ov[2], od[2];
  logic [47:0] ipix[2];
  logic [23:0] op[2];

  assign ifa.in_valid = iv[0];  assign ifa.in_sof = isof[0];  assign ifa.in_pix = ipix[0];
  assign ifb.in_valid = iv[1];  assign ifb.in_sof = isof[1];  assign ifb.in_pix = ipix[1];
  assign ov[0] = ifa.out_valid; assign op[0] = ifa.out_pix;   assign od[0] = ifa.frame_done;
  assign ov[1] = ifb.out_valid; assign op[1] = ifb.out_pix;   assign od[1] = ifb.frame_done;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int last_cyc[2];
  obs_t obsa[$];
  obs_t obsb[$];
  obs_t o;

  // Model state: counters, the whole quantised frame, and what the outputs must show next.
  int          m_col[2], m_row[2];
  int          fr[2][4][4][3];
  logic        exp_v[2], exp_d[2];
  logic [23:0] exp_p[2];

  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  function automatic int hd(input int d);
    return (d == 0) ? 2 : 4;
  endfunction

  function automatic int quant(input logic [15:0] x);
    int v;
    v = x[15] ? 0 : int'(x);
`ifdef RELU_POOL_ROUND_EN
    v = v + (1 << (SH - 1));
`endif
    v = v / (1 << SH);
    return (v > 255) ? 255 : v;
  endfunction

  function automatic int ec(input int d);
    return isof[d] ? 0 : m_col[d];
  endfunction

  function automatic int er(input int d);
    return isof[d] ? 0 : m_row[d];
  endfunction

  // Max of the current pixel and the three earlier pixels of its 2x2 window.
  function automatic logic [23:0] pool(input int d);
    int r, c, m;
    logic [23:0] res;
    r = er(d); c = ec(d); res = '0;
    for (int k = 0; k < 3; k++) begin
      m = quant(ipix[d][47-16*k -: 16]);
      for (int dr = 0; dr < 2; dr++)
        for (int dc = 0; dc < 2; dc++)
          if (dr + dc > 0 && fr[d][r-dr][c-dc][k] > m) m = fr[d][r-dr][c-dc][k];
      res[23-8*k -: 8] = 8'(m);
    end
    return res;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_col[d] <= 0; m_row[d] <= 0;
        exp_v[d] <= 1'b0; exp_d[d] <= 1'b0; exp_p[d] <= '0;
      end else begin
        exp_v[d] <= 1'b0;
        exp_d[d] <= 1'b0;
        if (iv[d]) begin
          for (int k = 0; k < 3; k++) fr[d][er(d)][ec(d)][k] <= quant(ipix[d][47-16*k -: 16]);
          if (er(d) % 2 == 1 && ec(d) % 2 == 1) begin
            exp_v[d] <= 1'b1;
            exp_p[d] <= pool(d);
            exp_d[d] <= (er(d) == hd(d) - 1) && (ec(d) == 3);
          end
          if (ec(d) == 3) begin
            m_col[d] <= 0;
            m_row[d] <= (er(d) == hd(d) - 1) ? 0 : er(d) + 1;
          end else begin
            m_col[d] <= ec(d) + 1;
            m_row[d] <= er(d);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      chk(ov[d] === exp_v[d], $sformatf("out_valid[%0d]@%0d", d, cyc), 32'(ov[d]), 32'(exp_v[d]));
      chk(op[d] === exp_p[d], $sformatf("out_pix[%0d]@%0d", d, cyc), 32'(op[d]), 32'(exp_p[d]));
      chk(od[d] === exp_d[d], $sformatf("frame_done[%0d]@%0d", d, cyc), 32'(od[d]), 32'(exp_d[d]));
      if (ov[d] === 1'b1) begin
        o.pix = op[d]; o.done = od[d]; o.cyc = cyc;
        if (d == 0) obsa.push_back(o); else obsb.push_back(o);
      end
    end
  end

  task automatic send(input int d, input logic [47:0] p, input bit s);
    @(posedge clk); #1;
    iv[d] = 1'b1; isof[d] = s; ipix[d] = p; last_cyc[d] = cyc;
  endtask

  task automatic idle(input int d, input int n);
    repeat (n) begin
      @(posedge clk); #1;
      iv[d] = 1'b0; isof[d] = 1'b0;
    end
  endtask

  function automatic logic [47:0] rnd48();
    return {16'($urandom), 16'($urandom), 16'($urandom)};
  endfunction

  function automatic logic [47:0] rndneg();
    return {1'b1, 15'($urandom), 1'b1, 15'($urandom), 1'b1, 15'($urandom)};
  endfunction

  task automatic rand_frames(input int d, input int nf);
    int junk;
    for (int f = 0; f < nf; f++) begin
      junk = $urandom_range(0, 3);
      for (int j = 0; j < junk; j++) begin
        send(d, rnd48(), 1'b0);
        idle(d, $urandom_range(0, 1));
      end
      for (int p = 0; p < 4 * hd(d); p++) begin
        send(d, rnd48(), p == 0);
        idle(d, $urandom_range(0, 2));
      end
    end
    idle(d, 3);
  endtask

  logic [47:0] gdat[16];
  logic [23:0] gref[4];
  int          incyc[16];
  int          br[4] = '{5, 7, 13, 15};
  logic [47:0] relu_frame[8];
  logic [23:0] rnd_exp;

  initial begin
    iv[0] = 1'b0; iv[1] = 1'b0; isof[0] = 1'b0; isof[1] = 1'b0;
    ipix[0] = '0; ipix[1] = '0;

    // Reset held three cycles while in_valid toggles.
    repeat (3) begin
      @(posedge clk); #1;
      iv[0] = ~iv[0]; iv[1] = iv[0]; ipix[0] = rnd48(); ipix[1] = rnd48();
      @(negedge clk);
      chk(ov[0] === 1'b0, "rst_out_valid", 32'(ov[0]), 0);
      chk(op[0] === 24'h0, "rst_out_pix", 32'(op[0]), 0);
      chk(od[0] === 1'b0, "rst_frame_done", 32'(od[0]), 0);
    end
    @(posedge clk); #1;
    rst = 1'b0; iv[0] = 1'b0; iv[1] = 1'b0;
    idle(0, 2);

    // Basic pool: uniform 0x0100 -> 2 per channel.
    obsa.delete();
    for (int p = 0; p < 8; p++) send(0, {3{16'h0100}}, p == 0);
    idle(0, 3);
    chk(obsa.size() == 2, "basic_count", obsa.size(), 2);
    if (obsa.size() == 2) begin
      chk(obsa[0].pix == 24'h020202, "basic_pix0", obsa[0].pix, 24'h020202);
      chk(obsa[1].pix == 24'h020202, "basic_pix1", obsa[1].pix, 24'h020202);
      chk(obsa[0].done == 1'b0, "basic_done0", 32'(obsa[0].done), 0);
      chk(obsa[1].done == 1'b1, "basic_done1", 32'(obsa[1].done), 1);
      chk(obsa[1].cyc - last_cyc[0] == 1, "basic_latency", obsa[1].cyc - last_cyc[0], 1);
    end

    // ReLU, max and saturation; second window is all negative.
    relu_frame[0] = {16'h8000, 16'h7FFF, 16'h0000};
    relu_frame[1] = {16'hFFFF, 16'h7FFF, 16'h0000};
    relu_frame[2] = rndneg();
    relu_frame[3] = rndneg();
    relu_frame[4] = {16'h0400, 16'h7FFF, 16'h0000};
    relu_frame[5] = {16'h0080, 16'h7FFF, 16'h0000};
    relu_frame[6] = rndneg();
    relu_frame[7] = rndneg();
    obsa.delete();
    for (int p = 0; p < 8; p++) send(0, relu_frame[p], p == 0);
    idle(0, 3);
    chk(obsa.size() == 2, "relu_count", obsa.size(), 2);
    if (obsa.size() == 2) begin
      chk(obsa[0].pix == 24'h08FF00, "relu_pix0", obsa[0].pix, 24'h08FF00);
      chk(obsa[1].pix == 24'h000000, "relu_negwin", obsa[1].pix, 24'h000000);
    end

    // SOF resync after three stray large pixels.
    obsa.delete();
    for (int p = 0; p < 3; p++) send(0, {3{16'h7FFF}}, 1'b0);
    for (int p = 0; p < 8; p++) send(0, {3{16'h0100}}, p == 0);
    idle(0, 3);
    chk(obsa.size() == 2, "sof_count", obsa.size(), 2);
    if (obsa.size() == 2) begin
      chk(obsa[0].pix == 24'h020202, "sof_pix0", obsa[0].pix, 24'h020202);
      chk(obsa[1].pix == 24'h020202, "sof_pix1", obsa[1].pix, 24'h020202);
      chk(obsa[1].done == 1'b1, "sof_done", 32'(obsa[1].done), 1);
    end

    // Gapped 4x4 frame must reproduce the gap-free results, one cycle after each bottom-right pixel.
    for (int p = 0; p < 16; p++) gdat[p] = rnd48();
    obsb.delete();
    for (int p = 0; p < 16; p++) send(1, gdat[p], p == 0);
    idle(1, 3);
    chk(obsb.size() == 4, "gapfree_count", obsb.size(), 4);
    for (int i = 0; i < 4; i++) gref[i] = (i < obsb.size()) ? obsb[i].pix : 24'hx;
    obsb.delete();
    for (int p = 0; p < 16; p++) begin
      send(1, gdat[p], p == 0);
      incyc[p] = last_cyc[1];
      if (p < 15) idle(1, $urandom_range(0, 3));
    end
    idle(1, 3);
    chk(obsb.size() == 4, "gapped_count", obsb.size(), 4);
    if (obsb.size() == 4)
      for (int i = 0; i < 4; i++) begin
        chk(obsb[i].pix === gref[i], $sformatf("gapped_pix%0d", i), obsb[i].pix, gref[i]);
        chk(obsb[i].cyc - incyc[br[i]] == 1, $sformatf("gapped_lat%0d", i),
            obsb[i].cyc - incyc[br[i]], 1);
      end

    // Rounding of 0x00C0: 1.5 LSB after the shift.
`ifdef RELU_POOL_ROUND_EN
    rnd_exp = 24'h020202;
`else
    rnd_exp = 24'h010101;
`endif
    obsa.delete();
    for (int p = 0; p < 8; p++) send(0, {3{16'h00C0}}, p == 0);
    idle(0, 3);
    chk(obsa.size() == 2, "round_count", obsa.size(), 2);
    if (obsa.size() == 2) begin
      chk(obsa[0].pix == rnd_exp, "round_pix0", obsa[0].pix, 32'(rnd_exp));
      chk(obsa[1].pix == rnd_exp, "round_pix1", obsa[1].pix, 32'(rnd_exp));
    end

    // Random frames on both instances with gaps and stray pixels; the per-cycle compare judges them.
    fork
      rand_frames(0, 6);
      rand_frames(1, 4);
    join

    // Reset in the middle of a frame, then a clean frame.
    send(0, rnd48(), 1'b1);
    for (int p = 0; p < 5; p++) send(0, rnd48(), 1'b0);
    @(posedge clk); #1;
    rst = 1'b1; iv[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    obsa.delete();
    rand_frames(0, 2);
    chk(obsa.size() == 4, "postrst_count", obsa.size(), 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/relu_pool_2x2.md
Name: relu_pool_2x2

Overview:
- Downstream consumer of the 3-channel filter ALU.
- Takes the 48-bit stream {p1,p2,p3}, one 16-bit signed channel each, and applies ReLU, requantisation to 8 bits with saturation, and 2x2 stride-2 max pooling over a raster-ordered image.
- Emits one 24-bit pooled pixel per 2x2 window.
- Sits between the ALU and the next conv/ALU stage or the frame writer.

Parameters:
- IMG_W, 28, input image width in pixels; must be even, >=2.
- IMG_H, 28, input image height in pixels; must be even, >=2.
- SHIFT, 7, right-shift applied after ReLU to requantise 16-bit to 8-bit; range 1..15.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_pix carries a pixel this cycle.
- in_sof  input  1  qualified by in_valid; marks pixel (row 0, col 0) of a frame.
- in_pix  input  48  [47:32]=ch0, [31:16]=ch1, [15:0]=ch2; each two's-complement 16-bit.
- out_valid  output  1  out_pix valid this cycle (single-cycle pulse per pooled pixel).
- out_pix  output  24  [23:16]=ch0, [15:8]=ch1, [7:0]=ch2; unsigned 8-bit each.
- frame_done  output  1  pulses with out_valid on the last pooled pixel of a frame.

Behaviour:
- Reset (rst=1 at clk edge):
  - col=0, row=0, out_valid=0, out_pix=0, frame_done=0, horizontal hold register=0.
  - Line buffer contents are not reset and are don't-care.
- Stream flow:
  - No backpressure; the block accepts every in_valid cycle.
  - Gaps in in_valid are allowed; counters and state advance only on in_valid=1.
- Per-channel arithmetic (combinational on input):
  - ReLU: v = (bit15 set) ? 0 : in.
  - q = v >> SHIFT.
  - Saturate: q8 = (q > 255) ? 255 : q[7:0].
- Counters:
  - col 0..IMG_W-1 and row 0..IMG_H-1.
  - On in_valid: col increments; at IMG_W-1 col wraps to 0 and row increments; at row IMG_H-1 row wraps to 0.
  - in_valid & in_sof: the pixel is treated as col=0, row=0 regardless of counter state. Counters become col=1, row=0.
  - Any partially built window from the prior frame is discarded. No output is produced from it.
- Horizontal stage:
  - Even col: hold register <= q8 (all three channels).
  - Odd col: hmax = per-channel max(hold, q8).
- Vertical stage:
  - Even row, odd col: line_buf[col>>1] <= hmax. The line buffer has IMG_W/2 entries of 24 bits.
  - Odd row, odd col: out_pix <= per-channel max(line_buf[col>>1], hmax).
- Output timing:
  - out_valid=1 the cycle after the accepting edge (latency 1 clk from the in_valid edge of the bottom-right window pixel).
  - out_valid is 0 in all other cycles.
  - out_pix holds its last value when out_valid=0.
- frame_done=1 in the same cycle as out_valid for the window whose bottom-right pixel is (row IMG_H-1, col IMG_W-1); 0 otherwise.
- Output count: (IMG_W/2)*(IMG_H/2) outputs per frame, in raster order of pooled coordinates.
- Reset mid-frame: everything returns to the reset state. A pending output does not appear.
- Simultaneous rst and in_valid: reset wins and the input is dropped.

Optional Feature:
- Macro: RELU_POOL_ROUND_EN.
- Defined: round-half-up before shift, q = (v + (1 << (SHIFT-1))) >> SHIFT, computed in 17 bits, then saturate to 255.
- Undefined: truncating shift as above.
- Latency and interface are identical either way.

Test Plan:
- Reset: hold rst 3 cycles with in_valid toggling -> out_valid=0, out_pix=24'h000000, frame_done=0 throughout; the first post-reset frame pools correctly.
- Basic pool (IMG_W=4, IMG_H=2, SHIFT=7): 8 pixels, all channels 16'h0100 -> exactly 2 outputs of 24'h020202. The 2nd output has frame_done=1 and appears 1 cycle after the 8th input.
- ReLU/max/saturation (IMG_W=4, IMG_H=2, SHIFT=7):
  - Window 0: ch0 values {16'h8000, 16'hFFFF, 16'h0400, 16'h0080}, ch1 all 16'h7FFF, ch2 all 0 -> out 24'h08FF00.
  - Negative inputs never win.
- SOF resync: feed 3 pixels, then a full 4x2 frame with in_sof on its first pixel -> exactly 2 outputs, aligned to the new frame. No output comes from the partial pixels.
- Gapped input: insert random 0-3 idle cycles between valid pixels of a 4x4 frame -> 4 outputs, values identical to the gap-free run, each 1 cycle after its bottom-right pixel.
- Rounding: all channels 16'h00C0, SHIFT=7, 4x2 frame -> out 24'h010101 without RELU_POOL_ROUND_EN and 24'h020202 with it.
